// File: rtl/conv_sched.sv
// Purpose: queues 16-bit integer jobs and runs each one through the memory-mapped int-to-half core.
// Latency: request at edge E0 into an idle block -> WR_LO at E1; response 8 cycles + core latency later.
// Backpressure: req_ready drops when the job FIFO is full; the FSM stalls in PUSH while the response register is held.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   req_valid/req_ready/req_data    16-bit two's-complement job input
//   rsp_valid/rsp_ready/rsp_data    half-precision result (0 on timeout)
//   rsp_err                         job aborted by the WAIT timeout
//   core_start/core_done            start/done handshake with the conversion core
//   mem_addr/mem_wr/mem_rd          core data-memory byte port
//   mem_wdata/mem_rdata             write byte / combinational read byte
//   busy                            FSM active or jobs queued
module conv_sched #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 4095
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        rsp_err,
    output logic        core_start,
    input  logic        core_done,
    output logic [7:0]  mem_addr,
    output logic        mem_wr,
    output logic        mem_rd,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        busy
);

    localparam int            AW   = $clog2(DEPTH);
    localparam int            CW   = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [15:0]   TMO  = 16'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_LO,
        S_WR_HI,
        S_START,
        S_WAIT,
        S_RD_LO,
        S_RD_HI,
        S_PUSH
    } state_t;

    // ---------------------------------------------------------------
    // Job FIFO
    // ---------------------------------------------------------------
    logic [15:0]   r_fifo [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    state_t        r_state;
    state_t        w_state_nxt;

    assign req_ready = (r_count != FULL);
    assign w_push    = req_valid && req_ready;
    assign w_pop     = (r_state == S_IDLE) && (r_count != '0);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wptr] <= req_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Job sequencing
    // ---------------------------------------------------------------
    logic [15:0] r_operand;
    logic [15:0] r_result;
    logic        r_err;
    logic        r_start_cnt;
    logic        r_done_low;
    logic [15:0] r_wait_cnt;
    logic        r_rsp_valid;
    logic [15:0] r_rsp_data;
    logic        r_rsp_err;

    logic        w_done_exit;
    logic        w_wait_last;
    logic        w_load_rsp;

    // done is only trusted after it has been seen low in this job's WAIT,
    // so a level left high by the previous job cannot end the wait early
    assign w_done_exit = core_done && r_done_low;
    assign w_wait_last = ((r_wait_cnt + 16'd1) == TMO);

    always_comb begin
        w_state_nxt = r_state;
        core_start  = 1'b0;
        mem_addr    = 8'd0;
        mem_wr      = 1'b0;
        mem_rd      = 1'b0;
        mem_wdata   = 8'd0;
        w_load_rsp  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_state_nxt = S_WR_LO;
                end
            end
            S_WR_LO: begin
                mem_addr    = 8'd0;
                mem_wr      = 1'b1;
                mem_wdata   = r_operand[7:0];
                w_state_nxt = S_WR_HI;
            end
            S_WR_HI: begin
                mem_addr    = 8'd1;
                mem_wr      = 1'b1;
                mem_wdata   = r_operand[15:8];
                w_state_nxt = S_START;
            end
            S_START: begin
                core_start = 1'b1;
                if (r_start_cnt) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_done_exit) begin
                    w_state_nxt = S_RD_LO;
                end else if (w_wait_last) begin
                    w_state_nxt = S_PUSH;
                end
            end
            S_RD_LO: begin
                mem_addr    = 8'd2;
                mem_rd      = 1'b1;
                w_state_nxt = S_RD_HI;
            end
            S_RD_HI: begin
                mem_addr    = 8'd3;
                mem_rd      = 1'b1;
                w_state_nxt = S_PUSH;
            end
            S_PUSH: begin
                if (!r_rsp_valid || rsp_ready) begin
                    w_load_rsp  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // a write landing on the reset edge would corrupt the core's memory
        // after the job has already been aborted
        if (reset) begin
            mem_wr = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_operand   <= 16'd0;
            r_result    <= 16'd0;
            r_err       <= 1'b0;
            r_start_cnt <= 1'b0;
            r_done_low  <= 1'b0;
            r_wait_cnt  <= 16'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 16'd0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_operand <= r_fifo[r_rptr];
                        r_result  <= 16'd0;
                        r_err     <= 1'b0;
                    end
                end
                S_START: begin
                    // toggles twice, so it is back to 0 for the next job
                    r_start_cnt <= ~r_start_cnt;
                    r_done_low  <= 1'b0;
                    r_wait_cnt  <= 16'd0;
                end
                S_WAIT: begin
                    r_wait_cnt <= r_wait_cnt + 16'd1;
                    if (!core_done) begin
                        r_done_low <= 1'b1;
                    end
                    if (!w_done_exit && w_wait_last) begin
                        r_err    <= 1'b1;
                        r_result <= 16'd0;
                    end
                end
                S_RD_LO: r_result[7:0]  <= mem_rdata;
                S_RD_HI: r_result[15:8] <= mem_rdata;
                default: ;
            endcase

            if (w_load_rsp) begin
                r_rsp_valid <= 1'b1;
                r_rsp_data  <= r_result;
                r_rsp_err   <= r_err;
            end else if (rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;
    assign busy      = (r_state != S_IDLE) || (r_count != '0);

endmodule

// File: tb/tb_conv_sched.sv
// Bench for conv_sched: paired core model, table-driven job vectors,
// hand-written multi-cycle sequences, and a randomized scoreboard.
module tb_conv_sched;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_data = 16'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic        core_start;
    logic        core_done = 1'b0;
    logic [7:0]  mem_addr;
    logic        mem_wr;
    logic        mem_rd;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        busy;

    conv_sched dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .core_start(core_start), .core_done(core_done),
        .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_rd(mem_rd),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference int16 -> binary16 conversion, round to nearest even.
    function automatic logic [15:0] to_half(input logic [15:0] v);
        int val;
        int m;
        int e;
        int frac;
        int sh;
        int rem;
        int hlf;
        val = int'($signed(v));
        if (val == 0) return 16'h0000;
        m = (val < 0) ? -val : val;
        e = 0;
        while ((m >> (e + 1)) != 0) e++;
        if (e <= 10) begin
            frac = m << (10 - e);
        end else begin
            sh   = e - 10;
            frac = m >> sh;
            rem  = m - (frac << sh);
            hlf  = 1 << (sh - 1);
            if (rem > hlf || (rem == hlf && (frac & 1) == 1)) frac++;
            if (frac == 2048) begin
                frac = 1024;
                e++;
            end
        end
        return {(val < 0) ? 1'b1 : 1'b0, 5'(e + 15), 10'(frac & 'h3FF)};
    endfunction

    // ---------------- paired core model ----------------
    // mode 0: normal, latency 2..6; mode 1: done stuck high; mode 2: latency 50
    int         core_mode = 0;
    int         core_cnt = 0;
    logic       prev_start = 1'b0;
    logic [7:0] cmem [256];

    initial begin
        for (int i = 0; i < 256; i++) cmem[i] = 8'h00;
    end

    assign mem_rdata = cmem[mem_addr];

    always @(posedge clk) begin
        if (mem_wr) cmem[mem_addr] <= mem_wdata;
        prev_start <= core_start;
        if (core_mode == 1) begin
            core_done <= 1'b1;
            core_cnt  <= 0;
        end else if (core_start && !prev_start) begin
            core_done <= 1'b0;
            core_cnt  <= (core_mode == 2) ? 50 : int'($urandom_range(2, 6));
        end else if (core_cnt != 0) begin
            core_cnt <= core_cnt - 1;
            if (core_cnt == 1) begin
                {cmem[3], cmem[2]} <= to_half({cmem[1], cmem[0]});
                core_done <= 1'b1;
            end
        end
    end

    // ---------------- monitors ----------------
    logic [16:0] got_q[$];
    logic [15:0] acc_q[$];
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    int          st_cnt = 0;

    always @(negedge clk) begin
        if (!reset && rsp_valid && rsp_ready) got_q.push_back({rsp_err, rsp_data});
        if (!reset && req_valid && req_ready) acc_q.push_back(req_data);
        if (mem_wr) wr_cnt++;
        if (mem_rd) rd_cnt++;
        if (core_start) st_cnt++;
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req_ready"}, req_ready, 1);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_data"}, rsp_data, 0);
        chk({tag, "_rsp_err"}, rsp_err, 0);
        chk({tag, "_core_start"}, core_start, 0);
        chk({tag, "_mem_wr"}, mem_wr, 0);
        chk({tag, "_mem_rd"}, mem_rd, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // offer one job, return 1 ns after the accepting edge
    task automatic push_job(input logic [15:0] d);
        int guard = 0;
        req_data  = d;
        req_valid = 1'b1;
        while (!req_ready && guard < 10000) begin
            tick();
            guard++;
        end
        chk("push_ready", req_ready, 1);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int n, input int lim);
        int c = 0;
        while (got_q.size() < n && c < lim) begin
            tick();
            c++;
        end
        chk("rsp_count", got_q.size(), n);
    endtask

    task automatic wait_start_end();
        int c = 0;
        while (!core_start && c < 50) begin tick(); c++; end
        while (core_start && c < 50) begin tick(); c++; end
        chk("start_seen_and_ended", (c < 50) ? 1 : 0, 1);
    endtask

    typedef struct {
        logic [15:0] din;
        logic [15:0] exp_dat;
        logic        exp_err;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int b_g;
        int b_w;
        int b_r;
        int b_s;
        int b_a;
        int n;
        int n_off;
        int cyc;

        tbl[0] = '{16'h0400, 16'h6400, 1'b0};
        tbl[1] = '{16'hFFFF, 16'hBC00, 1'b0};
        tbl[2] = '{16'h0000, 16'h0000, 1'b0};
        tbl[3] = '{16'h8000, 16'hF800, 1'b0};
        tbl[4] = '{16'h0001, 16'h3C00, 1'b0};

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk_reset_vals("rst");

        // ---- single job 0x0001 with cycle-exact sequencing ----
        b_g = got_q.size();
        b_s = st_cnt;
        push_job(16'h0001);
        chk("e0_busy", busy, 1);
        chk("e0_no_wr", mem_wr, 0);
        tick();
        chk("wr_lo", {mem_wr, mem_addr, mem_wdata}, {1'b1, 8'h00, 8'h01});
        tick();
        chk("wr_hi", {mem_wr, mem_addr, mem_wdata}, {1'b1, 8'h01, 8'h00});
        tick();
        chk("start1", core_start, 1);
        tick();
        chk("start2", core_start, 1);
        tick();
        chk("start_drop", core_start, 0);
        wait_rsp(b_g + 1, 200);
        chk("mem0", cmem[0], 8'h01);
        chk("mem1", cmem[1], 8'h00);
        chk("start_cycles", st_cnt - b_s, 2);
        chk("single_rsp", got_q[b_g], {1'b0, 16'h3C00});

        // ---- five queued jobs from the table ----
        repeat (3) tick();
        b_g = got_q.size();
        for (int i = 0; i < 5; i++) push_job(tbl[i].din);
        chk("ready_low_4_pending", req_ready, 0);
        wait_rsp(b_g + 5, 500);
        for (int i = 0; i < 5; i++)
            chk($sformatf("tbl%0d", i), got_q[b_g + i], {tbl[i].exp_err, tbl[i].exp_dat});

        // ---- response backpressure stalls in PUSH ----
        repeat (3) tick();
        rsp_ready = 1'b0;
        b_g = got_q.size();
        b_w = wr_cnt;
        push_job(16'h0400);
        push_job(16'hFFFF);
        push_job(16'h0000);
        repeat (150) tick();
        chk("hold_valid", rsp_valid, 1);
        chk("hold_data", rsp_data, 16'h6400);
        chk("hold_writes", wr_cnt - b_w, 4);
        chk("hold_busy", busy, 1);
        rsp_ready = 1'b1;
        wait_rsp(b_g + 3, 300);
        chk("drain0", got_q[b_g], {1'b0, 16'h6400});
        chk("drain1", got_q[b_g + 1], {1'b0, 16'hBC00});
        chk("drain2", got_q[b_g + 2], {1'b0, 16'h0000});

        // ---- timeout with done stuck high ----
        repeat (3) tick();
        core_mode = 1;
        repeat (2) tick();
        b_r = rd_cnt;
        push_job(16'h1234);
        wait_start_end();
        n = 0;
        while (!rsp_valid && n < 5000) begin
            n++;
            tick();
        end
        chk("tmo_cycles", n, 4096);
        chk("tmo_err", rsp_err, 1);
        chk("tmo_data", rsp_data, 0);
        chk("tmo_no_read", rd_cnt - b_r, 0);
        core_mode = 0;
        repeat (2) tick();
        b_g = got_q.size();
        push_job(16'h0001);
        wait_rsp(b_g + 1, 200);
        chk("after_tmo", got_q[b_g], {1'b0, 16'h3C00});

        // ---- reset during WAIT with two jobs queued ----
        repeat (3) tick();
        core_mode = 2;
        push_job(16'h0100);
        push_job(16'h0200);
        push_job(16'h0300);
        wait_start_end();
        repeat (2) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_reset_vals("midrst");
        b_g = got_q.size();
        b_w = wr_cnt;
        repeat (200) tick();
        chk("flush_no_rsp", got_q.size(), b_g);
        chk("flush_no_wr", wr_cnt - b_w, 0);
        chk("flush_idle", busy, 0);
        core_mode = 0;
        push_job(16'h0001);
        wait_rsp(b_g + 1, 200);
        chk("after_rst", got_q[b_g], {1'b0, 16'h3C00});

        // ---- randomized jobs against the reference conversion ----
        repeat (3) tick();
        b_g = got_q.size();
        b_a = acc_q.size();
        n_off = 0;
        cyc = 0;
        while (got_q.size() - b_g < 100 && cyc < 30000) begin
            if (req_valid && acc_q.size() - b_a == n_off) req_valid = 1'b0;
            if (!req_valid && n_off < 100 && $urandom_range(0, 3) != 0) begin
                req_data  = 16'($urandom);
                req_valid = 1'b1;
                n_off++;
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
            cyc++;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        chk("rand_count", got_q.size() - b_g, 100);
        if (got_q.size() - b_g >= 100 && acc_q.size() - b_a >= 100) begin
            for (int i = 0; i < 100; i++)
                chk($sformatf("rand%0d", i), got_q[b_g + i], {1'b0, to_half(acc_q[b_a + i])});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/conv_sched.md
# conv_sched

Job scheduler that sequences the int-to-float conversion core. It queues 16-bit integer requests and stages each operand into data-memory bytes 0–1. It then runs the core's start/done handshake, reads the result from bytes 2–3, and returns it on a response port. The core is treated as a memory-mapped, single-job resource; this block is its only master.

## Interface
- DEPTH, 4: job FIFO entries (power of two, ≥2)
- TIMEOUT, 4095: max WAIT cycles before the job is aborted
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req_valid  in  1  request offered
- req_ready  out  1  FIFO not full
- req_data  in  16  two's-complement integer
- rsp_valid  out  1  response register full
- rsp_ready  in  1  consumer takes response
- rsp_data  out  16  half-precision result, or 0 on error
- rsp_err  out  1  job timed out
- core_start  out  1  start request to core
- core_done  in  1  core acknowledge
- mem_addr  out  8  data-memory byte address
- mem_wr  out  1  write enable
- mem_rd  out  1  read enable
- mem_wdata  out  8  write byte
- mem_rdata  in  8  read byte, combinational from mem_addr
- busy  out  1  FSM not in IDLE or FIFO non-empty

## Operation
- Request accept: req_valid && req_ready at a rising edge pushes req_data. A simultaneous push and pop on a full FIFO is not allowed, because req_ready is low when the FIFO is full. A push and pop on a non-full FIFO both take effect in the same cycle.
- FIFO pointers wrap modulo DEPTH. Occupancy counter width is log2(DEPTH)+1.
- FSM states: IDLE, WR_LO, WR_HI, START, WAIT, RD_LO, RD_HI, PUSH.
- IDLE: if the FIFO is non-empty, pop the head into the operand register and go to WR_LO.
- WR_LO: mem_addr=0, mem_wr=1, mem_wdata=operand[7:0]. Go to WR_HI.
- WR_HI: mem_addr=1, mem_wr=1, mem_wdata=operand[15:8]. Go to START.
- START: core_start=1 for exactly 2 cycles, counted by an internal bit. Clear the done_low flag. Go to WAIT.
- WAIT: core_start=0. Set done_low when core_done==0.
  - Exit to RD_LO on core_done==1 && done_low. A stale high done from the previous job is never accepted.
  - A 16-bit wait counter increments each WAIT cycle. When it reaches TIMEOUT, set err and go to PUSH with result=0.
- RD_LO: mem_addr=2, mem_rd=1, capture result[7:0]=mem_rdata. Go to RD_HI.
- RD_HI: mem_addr=3, mem_rd=1, capture result[15:8]. Go to PUSH.
- PUSH: load {rsp_data, rsp_err} and set rsp_valid if the response register is empty or is being drained this cycle (rsp_ready). Otherwise stall in PUSH. Then go to IDLE.
- Response register: rsp_valid clears on rsp_ready when not reloaded in the same cycle.
- When not written, mem_addr=0, mem_wr=0, mem_rd=0, mem_wdata=0.

## Timing
- Reset values: req_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0, core_start=0, mem_wr=0, mem_rd=0, mem_addr=0, mem_wdata=0, busy=0. FSM=IDLE, FIFO empty, counters 0.
- Reset mid-operation (any state) aborts the job. The FIFO and the pending response are discarded, and core_start drops the next cycle. No memory write is issued after reset is sampled.
- Request accepted at edge E0 into an idle, empty block: WR_LO during cycle E1–E2, WR_HI E2–E3, START E3–E5, WAIT from E5.
- Core completion latency is N cycles. rsp_valid rises 3 edges after the exit from WAIT (RD_LO, RD_HI, PUSH), if rsp_ready has been held high.
- Back-to-back jobs: the FSM re-enters WR_LO one cycle after PUSH. Total overhead is 8 cycles plus the core latency.
- Timeout: err response appears 1 edge after the TIMEOUT-th WAIT cycle. The core is not reset; the next job proceeds normally.
- req_ready and busy are registered-state functions with no combinational path from req_valid.

## Test plan
- Single job 16'h0001 with the paired core model → mem bytes 0/1 = 01/00, core_start high 2 cycles, rsp_data=16'h3C00, rsp_err=0.
- Queue 5 jobs {0x0400, 0xFFFF, 0x0000, 0x8000, 0x0001} with rsp_ready=1. Required responses, in order: 0x6400, 0xBC00, 0x0000, 0xF800, 0x3C00. req_ready must drop while 4 jobs are pending.
- Hold rsp_ready=0 across 2 completed jobs → FSM stalls in PUSH holding 0xBC00, and no third memory write occurs. Releasing rsp_ready drains in order.
- Core model with done tied high (stale) then never low → no RD_LO. After TIMEOUT cycles, rsp_err=1 and rsp_data=0. The next job with a working core returns correct data.
- Assert reset for 1 cycle during WAIT with 2 jobs queued → all outputs return to reset values, and no response is produced for the flushed jobs. A new job 0x0001 then returns 0x3C00.
- Simultaneous push and pop on a FIFO holding 2 entries → occupancy unchanged and order preserved, checked by a scoreboard over 100 random jobs against a reference conversion model.
